mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default timing/geometry constants for the memory responder.
package mem_pkg;

    localparam int DEF_AW         = 8;
    localparam int DEF_READ_WAIT  = 3;
    localparam int DEF_WRITE_WAIT = 3;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_e;

endpackage

// File: rtl/mem_array.sv
// 2^AW x 16 storage: synchronous write, combinational read on a single shared address.
module mem_array
    import mem_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [2**AW];

    // No reset: contents survive Reset_n.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the CPU control unit; optional access counters
// are enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_Ready,
    output logic        Mem_Conflict
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0] Rd_Count,
    output logic [15:0] Wr_Count
`endif
);

    localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    word_t         data_q, data_d;
    logic          rd_ready_q, rd_ready_d;
    logic          conflict_q, conflict_d;
    logic          wr_en;
    logic          rd_done;
    word_t         rdata;

    mem_array #(.AW(AW)) u_array (
        .clk_i   (Clk),
        .we_i    (wr_en),
        .addr_i  (addr_q),
        .wdata_i (Data_from_CPU),
        .rdata_o (rdata)
    );

    if (AW < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^ADDR[15:AW];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_ready_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_ready_q <= rd_ready_d;
            conflict_q <= conflict_d;
        end
    end

    // The IDLE cycle counts as the first request cycle, so RD_WAIT finishes one cycle
    // short of READ_WAIT and WR_WAIT commits in the cycle holding count WRITE_WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_ready_d = 1'b0;
        conflict_d = conflict_q;
        wr_en      = 1'b0;
        rd_done    = 1'b0;

        if (Mem_OE && Mem_WE) begin
            conflict_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Mem_OE || Mem_WE) begin
                        state_d = Mem_OE ? RD_WAIT : WR_WAIT;
                        addr_d  = ADDR[AW-1:0];
                        cnt_d   = CW'(1);
                    end
                end
                RD_WAIT: begin
                    if (!Mem_OE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (int'(cnt_q) >= READ_WAIT - 1) begin
                        data_d     = rdata;
                        rd_ready_d = 1'b1;
                        rd_done    = 1'b1;
                        state_d    = RD_DONE;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RD_DONE: begin
                    if (!Mem_OE) begin
                        state_d = IDLE;
                    end
                end
                WR_WAIT: begin
                    if (!Mem_WE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (int'(cnt_q) >= WRITE_WAIT) begin
                        wr_en   = 1'b1;
                        state_d = WR_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WR_DONE: begin
                    if (!Mem_WE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign Data_to_CPU  = data_q;
    assign Mem_Ready    = rd_ready_q | wr_en;
    assign Mem_Conflict = conflict_q;

`ifdef MEM_RESPONDER_STATS_EN
    function automatic word_t sat_inc(input word_t v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    word_t rd_cnt_q, wr_cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_done) rd_cnt_q <= sat_inc(rd_cnt_q);
            if (wr_en)   wr_cnt_q <= sat_inc(wr_cnt_q);
        end
    end

    assign Rd_Count = rd_cnt_q;
    assign Wr_Count = wr_cnt_q;
`else
    logic unused_rd_done;
    assign unused_rd_done = rd_done;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed accesses with hand-computed timing and data.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] ADDR = 16'h0;
    logic [15:0] Data_from_CPU = 16'h0;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready;
    logic        Mem_Conflict;
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] Rd_Count;
    logic [15:0] Wr_Count;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_q;

    mem_responder dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .ADDR          (ADDR),
        .Data_from_CPU (Data_from_CPU),
        .Data_to_CPU   (Data_to_CPU),
        .Mem_Ready     (Mem_Ready),
        .Mem_Conflict  (Mem_Conflict)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .Rd_Count      (Rd_Count),
        .Wr_Count      (Wr_Count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, check Mem_Ready mid-cycle.
    task automatic cyc(input logic oe, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic rdy, input string name);
        @(posedge Clk);
        #1;
        Mem_OE = oe;
        Mem_WE = we;
        ADDR = a;
        Data_from_CPU = d;
        @(negedge Clk);
        check(name, 16'(Mem_Ready), 16'(rdy));
    endtask

    // Address is scrambled after the first cycle; the responder must ignore it.
    task automatic rd(input logic [15:0] a, input int n, input int rdy_at,
                      input logic [15:0] exp, input string name);
        if (rdy_at != 0) sb.push_back(exp);
        for (int c = 1; c <= n; c++)
            cyc(1'b1, 1'b0, (c == 1) ? a : (a ^ 16'h00FF), 16'h0, (c == rdy_at), name);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, {name, "_idle"});
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input int n,
                      input int rdy_at, input string name);
        for (int c = 1; c <= n; c++)
            cyc(1'b0, 1'b1, (c == 1) ? a : (a ^ 16'h00FF), d, (c == rdy_at), name);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, {name, "_idle"});
    endtask

    // Read-data monitor: every read acknowledge pops one expected word.
    always @(negedge Clk) begin
        if (Reset_n && Mem_Ready && Mem_OE && !Mem_WE) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_read_ready: Data_to_CPU %h, no read outstanding", Data_to_CPU);
            end else begin
                exp_q = sb.pop_front();
                check("read_data", Data_to_CPU, exp_q);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_data", Data_to_CPU, 16'h0000);
        check("rst_ready", 16'(Mem_Ready), 16'h0);
        check("rst_conflict", 16'(Mem_Conflict), 16'h0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // basic write then long read: single ready pulse, data held
        wr(16'h0012, 16'hBEEF, 4, 4, "wr_beef");
        rd(16'h0012, 6, 4, 16'hBEEF, "rd_beef");
        check("rd_data_held", Data_to_CPU, 16'hBEEF);

        // aborted read keeps previous output
        wr(16'h0020, 16'h1111, 4, 4, "wr_1111");
        rd(16'h0020, 2, 0, 16'h0, "rd_abort");
        check("abort_keeps_data", Data_to_CPU, 16'hBEEF);
        rd(16'h0020, 4, 4, 16'h1111, "rd_1111");

        // aborted write leaves the word alone
        wr(16'h0012, 16'h9999, 3, 0, "wr_abort");
        rd(16'h0012, 4, 4, 16'hBEEF, "rd_after_wr_abort");

        // conflict in the commit cycle of a write
        wr(16'h0030, 16'h7777, 4, 4, "wr_7777");
        check("conflict_clear", 16'(Mem_Conflict), 16'h0);
        cyc(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, "cf_c1");
        cyc(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, "cf_c2");
        cyc(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, "cf_c3");
        cyc(1'b1, 1'b1, 16'h0030, 16'h1234, 1'b0, "cf_c4");
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "cf_idle");
        check("conflict_set", 16'(Mem_Conflict), 16'h1);
        rd(16'h0030, 4, 4, 16'h7777, "rd_after_conflict");
        check("conflict_sticky", 16'(Mem_Conflict), 16'h1);

        // reset pulse in cycle 3 of a write
        wr(16'h0005, 16'h0BAD, 4, 4, "wr_0bad");
        cyc(1'b0, 1'b1, 16'h0005, 16'hAAAA, 1'b0, "rw_c1");
        cyc(1'b0, 1'b1, 16'h0005, 16'hAAAA, 1'b0, "rw_c2");
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #2;
        check("midrst_data", Data_to_CPU, 16'h0000);
        check("midrst_ready", 16'(Mem_Ready), 16'h0);
        check("midrst_conflict", 16'(Mem_Conflict), 16'h0);
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
        Mem_WE = 1'b0;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "rw_idle");
        rd(16'h0005, 4, 4, 16'h0BAD, "rd_after_reset");

        // address wrap from a clean reset
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        wr(16'h0107, 16'h5555, 4, 4, "wr_wrap");
        rd(16'h0007, 4, 4, 16'h5555, "rd_wrap");
`ifdef MEM_RESPONDER_STATS_EN
        check("rd_count", Rd_Count, 16'd1);
        check("wr_count", Wr_Count, 16'd1);
`endif
        check("sb_drained", 16'(sb.size()), 16'h0);

        repeat (2) @(posedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
